// File: rtl/sar_adc4_ctrl.sv
// sar_adc4_ctrl: successive-approximation ADC controller.
// Drives a trial code to the DAC, reads one comparator bit per trial
// (MSB first) and publishes the final code with a one-cycle done pulse.
// Optional macro SAR_SETTLE_EN inserts a WAIT state of SETTLE_CYCLES
// cycles before each comparator sample so the DAC output can settle.
//
// Handshake: start is a level request sampled only in IDLE; each accepted
// request produces exactly one done pulse, and result is valid from that
// pulse until the next one. Requests while busy or done are ignored.
module sar_adc4_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic             busy,
    output logic [WIDTH-1:0] dac_code,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);

    // Settle count must fit the 4-bit counter and be at least one cycle.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 1..15");
    end

`ifdef SAR_SETTLE_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        CONVERT = 3'd2,
        DONE    = 3'd3,
        WAIT    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;
`endif

    state_t state;
    state_t state_n;

    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] resolved;

`ifdef SAR_SETTLE_EN
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    logic [3:0] settle_cnt;
`endif

    // Current trial bit, and the trial code with that bit resolved by cmp.
    always_comb begin
        bit_mask = ONE << bit_idx;
        resolved = cmp ? dac_code : (dac_code & ~bit_mask);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_n = state;
        sample  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = SAMPLE;
            end
            SAMPLE: begin
                sample = 1'b1;
                busy   = 1'b1;
`ifdef SAR_SETTLE_EN
                state_n = WAIT;
`else
                state_n = CONVERT;
`endif
            end
            CONVERT: begin
                busy = 1'b1;
                if (bit_idx == '0) state_n = DONE;
`ifdef SAR_SETTLE_EN
                else               state_n = WAIT;
`endif
            end
`ifdef SAR_SETTLE_EN
            WAIT: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) state_n = CONVERT;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Trial code, bit index and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_code <= '0;
            result   <= '0;
            bit_idx  <= TOP_IDX;
        end else begin
            case (state)
                IDLE: begin
                    dac_code <= '0;
                    bit_idx  <= TOP_IDX;
                end
                SAMPLE: begin
                    dac_code <= MSB;
                    bit_idx  <= TOP_IDX;
                end
                CONVERT: begin
                    if (bit_idx == '0) begin
                        result   <= resolved;
                        dac_code <= resolved;
                    end else begin
                        dac_code <= resolved | (bit_mask >> 1);
                        bit_idx  <= bit_idx - 1'b1;
                    end
                end
                DONE: begin
                    dac_code <= '0;
                end
                default: begin
                    dac_code <= dac_code;
                end
            endcase
        end
    end

`ifdef SAR_SETTLE_EN
    // Settle counter: loaded whenever a new trial code is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 4'd0;
        end else if (state == SAMPLE || (state == CONVERT && bit_idx != '0)) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == WAIT && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sar_adc4_ctrl.sv
// tb_sar_adc4_ctrl: directed-vector bench for sar_adc4_ctrl with a
// combinational comparator model and queue-based result/trial scoreboard.
module tb_sar_adc4_ctrl;

    localparam int W = 4;
    localparam int S = 2;
`ifdef SAR_SETTLE_EN
    localparam int HOLD = S + 1;
`else
    localparam int HOLD = 1;
`endif
    // Edge offset from start acceptance to the edge that opens the done cycle.
    localparam int LAT = W * HOLD + 1;
    localparam int PER = LAT + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cmp;
    logic         sample;
    logic         busy;
    logic [W-1:0] dac_code;
    logic [W-1:0] result;
    logic         done;
    logic [W-1:0] vin;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    logic [W-1:0] trial_q[$];
    logic [W-1:0] exp_q[$];
    int           cyc_q[$];

    sar_adc4_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cmp     (cmp),
        .sample  (sample),
        .busy    (busy),
        .dac_code(dac_code),
        .result  (result),
        .done    (done)
    );

    // Comparator model.
    assign cmp = (vin >= dac_code);

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Queue expected trials (each held HOLD cycles) and the final result.
    task automatic push_conv(input logic [4*W-1:0] trials, input logic [W-1:0] res);
        for (int t = 0; t < W; t++)
            for (int h = 0; h < HOLD; h++)
                trial_q.push_back(trials[4*W-1-4*t -: W]);
        exp_q.push_back(res);
    endtask

    // Single conversion with a one-cycle start pulse.
    task automatic convert(input logic [W-1:0] v, input logic [4*W-1:0] trials,
                           input logic [W-1:0] res);
        int c0;
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        push_conv(trials, res);
        @(posedge clk);
        #1 c0 = cyc;
        cyc_q.push_back(c0 + LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 2) @(posedge clk);
    endtask

    // Monitor: trials during busy (non-sample) cycles, results on done.
    always @(negedge clk) begin
        if (!reset) begin
            if (sample) check("sample_dac_zero", 32'(dac_code), 32'd0);
            if (busy && !sample) begin
                if (trial_q.size() == 0) check("unexpected_trial", 32'(dac_code), 32'hffff);
                else check("trial", 32'(dac_code), 32'(trial_q.pop_front()));
            end
            if (done) begin
                check("busy_in_done", 32'(busy), 32'd0);
                if (exp_q.size() == 0 || cyc_q.size() == 0) begin
                    check("unexpected_done", 32'(result), 32'hffff);
                end else begin
                    check("result", 32'(result), 32'(exp_q.pop_front()));
                    check("done_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int c0;
        reset = 1'b1;
        start = 1'b0;
        vin   = '0;
        #1;
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_dac",    32'(dac_code), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        convert(4'b1011, 16'b1000_1100_1010_1011, 4'b1011);
        convert(4'b0000, 16'b1000_0100_0010_0001, 4'b0000);
        convert(4'b1111, 16'b1000_1100_1110_1111, 4'b1111);

        // Start held high: three back-to-back conversions PER cycles apart.
        @(negedge clk);
        vin   = 4'b0110;
        start = 1'b1;
        for (int i = 0; i < 3; i++) push_conv(16'b1000_0100_0110_0111, 4'b0110);
        @(posedge clk);
        #1 c0 = cyc;
        for (int i = 0; i < 3; i++) cyc_q.push_back(c0 + LAT + i * PER);
        repeat (2 * PER) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 3) @(posedge clk);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        vin   = 4'b1011;
        start = 1'b1;
        trial_q.push_back(4'b1000);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_sample", 32'(sample), 32'd0);
        check("arst_busy",   32'(busy),   32'd0);
        check("arst_done",   32'(done),   32'd0);
        check("arst_dac",    32'(dac_code), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        convert(4'b0101, 16'b1000_0100_0110_0101, 4'b0101);
        convert(4'b1001, 16'b1000_1100_1010_1001, 4'b1001);

        repeat (4) @(posedge clk);
        check("trial_q_empty", 32'(trial_q.size()), 32'd0);
        check("exp_q_empty",   32'(exp_q.size()),   32'd0);
        check("cyc_q_empty",   32'(cyc_q.size()),   32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
